// File: rtl/cyc_counters_reader.sv
// rtl/cyc_counters_reader.sv - walks every cycle-accounting counter over the CSR port and streams a snapshot
// Includes minimal config_pkg / riscv definitions so the block elaborates on its own.

package config_pkg;
    typedef struct packed {
        int unsigned XLEN;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{XLEN: 32'd64};
endpackage

package riscv;
    localparam logic [11:0] CSR_CNT_STATUS = 12'h7C0;
    localparam logic [11:0] CSR_CNT_DATA   = 12'h7C1;
    localparam logic [11:0] CSR_CNT_DATA_H = 12'h7C2;
endpackage

module cyc_counters_reader #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg        = config_pkg::cva6_cfg_empty,
    parameter int unsigned           CycAccountRegs = 8,
    localparam int unsigned          IdxW           = (CycAccountRegs > 1) ? $clog2(CycAccountRegs) : 1,
    localparam int unsigned          XLEN           = CVA6Cfg.XLEN
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [11:0]     addr_o,
    output logic            we_o,
    output logic [XLEN-1:0] wdata_o,
    input  logic [XLEN-1:0] rdata_i,
    output logic            cnt_valid_o,
    input  logic            cnt_ready_i,
    output logic [IdxW-1:0] cnt_idx_o,
    output logic [63:0]     cnt_value_o
);

    localparam bit            Is32    = (XLEN == 32);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(CycAccountRegs - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_STATUS,
        S_SEL,
        S_RD_LO,
        S_RD_HI,
        S_EMIT,
        S_RESTORE,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [31:0]     status_q, status_d;
    logic [63:0]     value_q, value_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            status_q <= '0;
            value_q  <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            status_q <= status_d;
            value_q  <= value_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        status_d = status_q;
        value_d  = value_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_RD_STATUS;
                    idx_d   = '0;
                end
            end
            S_RD_STATUS: begin
                status_d = rdata_i[31:0];
                state_d  = S_SEL;
            end
            S_SEL: state_d = S_RD_LO;
            S_RD_LO: begin
                // 32-bit cores need a second access for the upper half; the pair is not atomic
                if (Is32) begin
                    value_d[31:0] = rdata_i[31:0];
                    state_d       = S_RD_HI;
                end else begin
                    value_d = 64'(rdata_i);
                    state_d = S_EMIT;
                end
            end
            S_RD_HI: begin
                value_d[63:32] = rdata_i[31:0];
                state_d        = S_EMIT;
            end
            S_EMIT: begin
                if (cnt_ready_i) begin
                    if (idx_q == LastIdx) begin
                        state_d = S_RESTORE;
                    end else begin
                        idx_d   = idx_q + IdxW'(1);
                        state_d = S_SEL;
                    end
                end
            end
            S_RESTORE: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o      = (state_q != S_IDLE);
        done_o      = 1'b0;
        addr_o      = riscv::CSR_CNT_STATUS;
        we_o        = 1'b0;
        wdata_o     = '0;
        cnt_valid_o = 1'b0;
        cnt_idx_o   = '0;
        cnt_value_o = '0;
        unique case (state_q)
            S_SEL: begin
                we_o          = 1'b1;
                wdata_o[31:0] = {status_q[31:16], 16'(idx_q)};
            end
            S_RD_LO: addr_o = riscv::CSR_CNT_DATA;
            S_RD_HI: addr_o = riscv::CSR_CNT_DATA_H;
            S_EMIT: begin
                cnt_valid_o = 1'b1;
                cnt_idx_o   = idx_q;
                cnt_value_o = value_q;
            end
            S_RESTORE: begin
                we_o          = 1'b1;
                wdata_o[31:0] = status_q;
            end
            S_DONE: done_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cyc_counters_reader.sv
// tb/tb_cyc_counters_reader.sv - table-driven scoreboard bench for cyc_counters_reader (XLEN 64 and 32 instances)
module tb_cyc_counters_reader;

    localparam config_pkg::cva6_cfg_t Cfg64 = '{XLEN: 32'd64};
    localparam config_pkg::cva6_cfg_t Cfg32 = '{XLEN: 32'd32};
    localparam int          N    = 8;
    localparam logic [11:0] A_ST = 12'h7C0;
    localparam logic [11:0] A_LO = 12'h7C1;
    localparam logic [11:0] A_HI = 12'h7C2;

    typedef struct {
        int          j;
        logic [31:0] status;
        bit          c4;
        int          stall_idx;
        int          stall_len;
        bit          pulse;
        int          exp_done;
    } vec_t;

    typedef struct {
        logic [2:0]  idx;
        logic [63:0] value;
        bit          ge;
    } sb_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic [1:0]       start, busy, done, we, vld, rdy;
    logic [1:0][11:0] addr;
    logic [1:0][2:0]  idx;
    logic [1:0][63:0] val;
    logic [1:0][63:0] wd;
    logic [1:0][63:0] rd;
    logic [63:0]      wd0;
    logic [31:0]      wd1;

    assign wd[0] = wd0;
    assign wd[1] = {32'b0, wd1};

    cyc_counters_reader #(.CVA6Cfg(Cfg64), .CycAccountRegs(N)) u_dut64 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[0]), .busy_o(busy[0]), .done_o(done[0]),
        .addr_o(addr[0]), .we_o(we[0]), .wdata_o(wd0), .rdata_i(rd[0]),
        .cnt_valid_o(vld[0]), .cnt_ready_i(rdy[0]), .cnt_idx_o(idx[0]), .cnt_value_o(val[0])
    );

    cyc_counters_reader #(.CVA6Cfg(Cfg32), .CycAccountRegs(N)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start[1]), .busy_o(busy[1]), .done_o(done[1]),
        .addr_o(addr[1]), .we_o(we[1]), .wdata_o(wd1), .rdata_i(rd[1][31:0]),
        .cnt_valid_o(vld[1]), .cnt_ready_i(rdy[1]), .cnt_idx_o(idx[1]), .cnt_value_o(val[1])
    );

    // Counter-block model: status CSR plus N counters, the enabled one stalls on CSR writes
    logic [63:0] cnt [2][N];
    logic [31:0] stat [2];
    int          ticks [2];
    logic [63:0] load_val [N];
    logic [31:0] load_status;
    int          load_j;
    logic        load_req;

    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (load_req && load_j == j) begin
                for (int k = 0; k < N; k++) cnt[j][k] <= load_val[k];
                stat[j]  <= load_status;
                ticks[j] <= 0;
            end else begin
                ticks[j] <= ticks[j] + 1;
                if (we[j] && addr[j] == A_ST) stat[j] <= wd[j][31:0];
                if (!we[j] && stat[j][31:16] < 16'd8)
                    cnt[j][stat[j][18:16]] <= cnt[j][stat[j][18:16]] + 64'd1;
            end
        end
    end

    always_comb begin
        rd = '0;
        for (int j = 0; j < 2; j++) begin
            if (addr[j] == A_ST)      rd[j] = {32'b0, stat[j]};
            else if (addr[j] == A_LO) rd[j] = (j == 0) ? cnt[j][stat[j][2:0]] : {32'b0, cnt[j][stat[j][2:0]][31:0]};
            else if (addr[j] == A_HI) rd[j] = {32'b0, cnt[j][stat[j][2:0]][63:32]};
        end
    end

    int   tests = 0;
    int   fails = 0;
    vec_t vecs[5];
    sb_t  sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_model(input int j, input logic [31:0] status, input bit c4);
        @(negedge clk);
        for (int k = 0; k < N; k++) load_val[k] = 64'(k) * 64'h1000;
        if (c4) load_val[4] = 64'h0000_0001_FFFF_0000;
        load_status = status;
        load_j      = j;
        load_req    = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    task automatic run(input vec_t v);
        int          wr = 0, stall = 0, ent = 0, nlo = 0, nhi = 0, lohi_bad = 0, wbad = 0, quiet_bad = 0, en;
        bit          got_done = 1'b0;
        logic [11:0] prev_a = A_ST;
        longint      lag;
        sb_t         e;
        load_model(v.j, v.status, v.c4);
        en = int'(v.status[31:16]);
        sb.delete();
        for (int k = 0; k < N; k++) sb.push_back('{idx: 3'(k), value: load_val[k], ge: (k == en)});
        start[v.j] = 1'b1;
        for (int c = 1; c <= 200 && !got_done; c++) begin
            @(negedge clk);
            start[v.j] = v.pulse && (c == 5 || c == 10);
            rdy[v.j]   = !(vld[v.j] && int'(idx[v.j]) == v.stall_idx && stall < v.stall_len);
            if (vld[v.j] && !rdy[v.j]) begin
                stall++;
                chk("bp_idx", 64'(idx[v.j]), 64'(v.stall_idx));
                chk("bp_value", val[v.j], load_val[v.stall_idx]);
                chk("bp_we", 64'(we[v.j]), 64'd0);
            end
            if (vld[v.j] && rdy[v.j]) begin
                ent++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_entry: got idx %0d with empty scoreboard", idx[v.j]);
                end else begin
                    e = sb.pop_front();
                    chk("entry_idx", 64'(idx[v.j]), 64'(e.idx));
                    if (e.ge) begin
                        tests++;
                        if (val[v.j] < e.value) begin
                            fails++;
                            $display("FAIL entry_value_ge: got 0x%0h want >= 0x%0h", val[v.j], e.value);
                        end
                    end else chk("entry_value", val[v.j], e.value);
                end
            end
            if (we[v.j]) begin
                wr++;
                if (wd[v.j][63:32] != 32'd0 || addr[v.j] != A_ST) wbad++;
            end
            if (addr[v.j] == A_HI) begin
                nhi++;
                if (prev_a != A_LO) lohi_bad++;
            end
            if (addr[v.j] == A_LO) nlo++;
            prev_a = addr[v.j];
            if (done[v.j]) begin
                got_done = 1'b1;
                chk("done_cycle", 64'(c), 64'(v.exp_done));
            end
        end
        start[v.j] = 1'b0;
        rdy[v.j]   = 1'b1;
        chk("done_seen", 64'(got_done), 64'd1);
        chk("entries", 64'(ent), 64'(N));
        chk("write_cycles", 64'(wr), 64'(N + 1));
        chk("write_shape", 64'(wbad), 64'd0);
        chk("status_restored", 64'(stat[v.j]), 64'(v.status));
        if (v.j == 1) begin
            chk("lo_reads", 64'(nlo), 64'(N));
            chk("hi_reads", 64'(nhi), 64'(N));
            chk("lo_hi_order", 64'(lohi_bad), 64'd0);
        end
        if (en < N) begin
            lag = longint'(ticks[v.j]) - longint'(cnt[v.j][en] - load_val[en]);
            chk("enabled_lag", 64'(lag), 64'(N + 1));
        end
        repeat (10) begin
            @(negedge clk);
            if (done[v.j] || busy[v.j]) quiet_bad++;
        end
        chk("idle_after_done", 64'(quiet_bad), 64'd0);
    endtask

    initial begin
        bit hit = 1'b0;
        rst_n    = 1'b0;
        start    = '0;
        rdy      = 2'b11;
        load_req = 1'b0;
        load_j   = 0;
        load_status = '0;
        vecs[0] = '{j: 0, status: 32'h0007_0002, c4: 0, stall_idx: -1, stall_len: 0, pulse: 0, exp_done: 27};
        vecs[1] = '{j: 0, status: 32'h0007_0002, c4: 0, stall_idx: -1, stall_len: 0, pulse: 1, exp_done: 27};
        vecs[2] = '{j: 0, status: 32'h0007_0002, c4: 0, stall_idx: 3,  stall_len: 5, pulse: 0, exp_done: 32};
        vecs[3] = '{j: 1, status: 32'h0000_0000, c4: 1, stall_idx: -1, stall_len: 0, pulse: 0, exp_done: 35};
        vecs[4] = '{j: 1, status: 32'h00FF_0001, c4: 0, stall_idx: 7,  stall_len: 3, pulse: 0, exp_done: 38};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            chk("rst_busy", 64'(busy[j]), 64'd0);
            chk("rst_done", 64'(done[j]), 64'd0);
            chk("rst_addr", 64'(addr[j]), 64'(A_ST));
            chk("rst_we", 64'(we[j]), 64'd0);
            chk("rst_wdata", wd[j], 64'd0);
            chk("rst_valid", 64'(vld[j]), 64'd0);
            chk("rst_idx", 64'(idx[j]), 64'd0);
            chk("rst_value", val[j], 64'd0);
        end

        for (int v = 0; v < 5; v++) run(vecs[v]);

        // Asynchronous reset while entry 2 is being offered
        load_model(0, 32'h0007_0002, 1'b0);
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        for (int c = 0; c < 60 && !hit; c++) begin
            if (vld[0] && idx[0] == 3'd2) hit = 1'b1;
            else @(negedge clk);
        end
        chk("reached_emit2", 64'(hit), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(vld[0]), 64'd0);
        chk("async_rst_busy", 64'(busy[0]), 64'd0);
        chk("async_rst_we", 64'(we[0]), 64'd0);
        chk("async_rst_addr", 64'(addr[0]), 64'(A_ST));
        @(negedge clk);
        rst_n = 1'b1;
        run(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
